// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit that sits between the
// execute stage and a gnt/rvalid style data-memory port. It captures one
// request, issues it to memory with lane-aligned address, byte enables and
// replicated store data, then returns an aligned, extended load result or an
// exception. A bounded wait in REQ and in RESP protects against a hung bus.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap accesses whose
// address is not a multiple of the access size instead of aligning them.
module load_store_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_unsigned,
  input  logic [1:0]            req_size,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic                  req_reg_wr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [XLEN/8-1:0]     dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic                  dmem_err,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  exc_valid,
  output logic [1:0]            exc_cause,
  output logic [XLEN-1:0]       exc_addr,
  output logic                  busy
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] CAUSE_BUS = 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [1:0] CAUSE_LD_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ST_MISALIGN = 2'b10;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t state_q, state_n;

  // Captured request fields.
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic                  write_q;
  logic [LANE_W-1:0]     lane_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_wr_q;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       daddr_q;
  logic [NB-1:0]         be_q;
  logic [XLEN-1:0]       wdata_q;

  logic [CNT_W-1:0]      cnt_q;
  logic                  timeout_hit;

  logic                  accept;
  logic                  wb_fire;
  logic                  exc_fire;
  logic [1:0]            exc_cause_n;
  logic [XLEN-1:0]       exc_addr_n;

  // Request decode: effective size, natural-alignment lane, enables, data.
  logic [1:0]            size_eff;
  int unsigned           req_nbytes;
  logic [LANE_W-1:0]     align_mask;
  logic [LANE_W-1:0]     req_lane;
  logic [NB-1:0]         size_be;
  logic [NB-1:0]         be_n;
  logic [XLEN-1:0]       wdata_n;
  logic [XLEN-1:0]       daddr_n;

  // Decode the incoming request into memory-side fields.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    size_eff   = (XLEN == 32 && req_size == 2'b11) ? 2'b10 : req_size;
    req_nbytes = 32'd1 << size_eff;
    align_mask = LANE_W'(req_nbytes - 32'd1);
    req_lane   = req_addr[LANE_W-1:0] & ~align_mask;
    size_be    = NB'((32'd1 << req_nbytes) - 32'd1);
    be_n       = size_be << req_lane;
    daddr_n    = {req_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
    wdata_n    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wdata_n[8*i +: 8] = req_wdata[8*(i & (req_nbytes - 32'd1)) +: 8];
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(req_addr[LANE_W-1:0] & align_mask);
`endif

  // Response decode: shift the addressed lane down, truncate and extend.
  logic [XLEN-1:0] rdata_shift;
  logic [XLEN-1:0] data_mask;
  logic [XLEN-1:0] load_data;
  logic            sign_bit;
  int unsigned     resp_nbytes;

  // Align, truncate and sign/zero-extend the load response.
  always_comb begin
    resp_nbytes = 32'd1 << size_q;
    rdata_shift = dmem_rdata >> (8 * lane_q);
    data_mask   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      data_mask[8*i +: 8] = (i < resp_nbytes) ? 8'hFF : 8'h00;
    end
    case (size_q)
      2'b00:   sign_bit = rdata_shift[7];
      2'b01:   sign_bit = rdata_shift[15];
      2'b10:   sign_bit = rdata_shift[31];
      default: sign_bit = rdata_shift[XLEN-1];
    endcase
    load_data = rdata_shift & data_mask;
    if (!unsigned_q && sign_bit) begin
      load_data = load_data | ~data_mask;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state logic and the single-cycle result/exception strobes.
  always_comb begin
    state_n     = state_q;
    accept      = 1'b0;
    wb_fire     = 1'b0;
    exc_fire    = 1'b0;
    exc_cause_n = CAUSE_BUS;
    exc_addr_n  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            exc_fire    = 1'b1;
            exc_cause_n = req_write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            exc_addr_n  = req_addr;
          end else begin
            state_n = S_REQ;
          end
`else
          state_n = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          state_n = S_RESP;
        end else if (timeout_hit) begin
          exc_fire = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          state_n = S_IDLE;
          if (dmem_err) begin
            exc_fire = 1'b1;
          end else begin
            wb_fire = !write_q;
          end
        end else if (timeout_hit) begin
          exc_fire = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register; the wait counter restarts on every state change.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      if (state_n != state_q || state_q == S_IDLE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Capture all request fields on acceptance.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      size_q     <= '0;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      lane_q     <= '0;
      rd_q       <= '0;
      reg_wr_q   <= 1'b0;
      addr_q     <= '0;
      daddr_q    <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      size_q     <= size_eff;
      unsigned_q <= req_unsigned;
      write_q    <= req_write;
      lane_q     <= req_lane;
      rd_q       <= req_rd;
      reg_wr_q   <= req_reg_wr;
      addr_q     <= req_addr;
      daddr_q    <= daddr_n;
      be_q       <= be_n;
      wdata_q    <= wdata_n;
    end
  end

  // Registered writeback and exception pulses with their payloads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
    end else begin
      wb_valid  <= wb_fire;
      exc_valid <= exc_fire;
      if (wb_fire) begin
        wb_we   <= reg_wr_q;
        wb_rd   <= rd_q;
        wb_data <= load_data;
      end
      if (exc_fire) begin
        exc_cause <= exc_cause_n;
        exc_addr  <= exc_addr_n;
      end
    end
  end

  // Memory-side outputs are only driven while the request is outstanding.
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = dmem_req & write_q;
  assign dmem_addr  = dmem_req ? daddr_q : '0;
  assign dmem_be    = dmem_req ? be_q : '0;
  assign dmem_wdata = dmem_req ? wdata_q : '0;

endmodule
